// File: rtl/mask_share_gen.sv
// mask_share_gen: masks bytes into three Boolean shares with 90 bits of S-box randomness from a seeded 128-bit LFSR
module mask_share_gen (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_load,
  input  logic [127:0] seed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_s1,
  output logic [7:0]   out_s2,
  output logic [7:0]   out_s3,
  output logic [89:0]  out_r,
  output logic         busy
);
  typedef enum logic [1:0] {UNSEEDED, WARMUP, RUN} state_t;
  state_t       state;
  logic [127:0] lfsr;
  logic [127:0] lfsr_nxt;
  logic [3:0]   cnt;
  logic         acc;
  function automatic logic [127:0] advance(input logic [127:0] s);
    logic [127:0] t;
    t = s;
    for (int i = 0; i < 128; i++) t = {t[126:0], t[127] ^ t[28] ^ t[26] ^ t[1]};
    return t;
  endfunction
  assign lfsr_nxt = advance(lfsr);
  assign in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign busy     = state != RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNSEEDED;
      lfsr      <= 128'd1;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      out_s1    <= 8'd0;
      out_s2    <= 8'd0;
      out_s3    <= 8'd0;
      out_r     <= 90'd0;
    end else if (seed_load) begin
      state     <= WARMUP;
      lfsr      <= (seed == 128'd0) ? 128'd1 : seed;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      out_s1    <= 8'd0;
      out_s2    <= 8'd0;
      out_s3    <= 8'd0;
      out_r     <= 90'd0;
    end else begin
      if (state == WARMUP) begin
        lfsr <= lfsr_nxt;
        cnt  <= cnt + 4'd1;
        if (cnt == 4'd15) state <= RUN;
      end
      if (acc) begin
        lfsr      <= lfsr_nxt;
        out_s1    <= in_data ^ lfsr[7:0] ^ lfsr[15:8];
        out_s2    <= lfsr[7:0];
        out_s3    <= lfsr[15:8];
        out_r     <= lfsr[105:16];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mask_share_gen.sv
// tb_mask_share_gen: randomized self-checking bench for mask_share_gen against a transaction-level model
module tb_mask_share_gen;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_load = 1'b0;
  logic [127:0] seed = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_s1, out_s2, out_s3;
  logic [89:0]  out_r;
  logic         busy;
  mask_share_gen dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3), .out_r(out_r), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] m = 128'd1;
  bit           run = 1'b0;
  int           wcnt = 0;
  bit           ev = 1'b0;
  bit           known = 1'b1;
  logic [7:0]   e1 = '0, e2 = '0, e3 = '0, eb = '0;
  logic [89:0]  er = '0;
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [127:0] prng(input logic [127:0] s);
    logic [127:0] t;
    t = s;
    for (int i = 0; i < 128; i++) t = {t[126:0], t[127] ^ t[28] ^ t[26] ^ t[1]};
    return t;
  endfunction
  task automatic post_chk();
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("lfsr", dut.lfsr, m);
    if (known) begin
      chk("out_s1", 128'(out_s1), 128'(e1));
      chk("out_s2", 128'(out_s2), 128'(e2));
      chk("out_s3", 128'(out_s3), 128'(e3));
      chk("out_r", 128'(out_r), 128'(er));
    end
    if (ev) chk("share_xor", 128'(out_s1 ^ out_s2 ^ out_s3), 128'(eb));
  endtask
  task automatic do_reset(input bit sl);
    rst = 1'b1;
    seed_load = sl;
    seed = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    m = 128'd1; run = 1'b0; wcnt = 0; ev = 1'b0; known = 1'b1;
    e1 = '0; e2 = '0; e3 = '0; eb = '0; er = '0;
    #1;
    rst = 1'b0;
    seed_load = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd1);
    post_chk();
  endtask
  task automatic step(input bit iv, input logic [7:0] d, input bit ordy, input bit sl, input logic [127:0] sd);
    bit exp_rdy;
    in_valid = iv; in_data = d; out_ready = ordy; seed_load = sl; seed = sd;
    #1;
    exp_rdy = run && !sl && (!ev || ordy);
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("busy", 128'(busy), 128'(!run));
    @(posedge clk);
    if (sl) begin
      m = (sd == 128'd0) ? 128'd1 : sd;
      run = 1'b0; wcnt = 16; ev = 1'b0; known = 1'b1;
      e1 = '0; e2 = '0; e3 = '0; eb = '0; er = '0;
    end else if (wcnt > 0) begin
      m = prng(m);
      wcnt--;
      run = (wcnt == 0);
    end else if (iv && exp_rdy) begin
      e2 = m[7:0]; e3 = m[15:8]; er = m[105:16]; eb = d; e1 = d ^ e2 ^ e3;
      ev = 1'b1; known = 1'b1;
      m = prng(m);
    end else if (ordy && ev) begin
      ev = 1'b0; known = 1'b0;
    end
    #1;
    post_chk();
  endtask
  task automatic rnd_steps(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, '0);
  endtask
  initial begin
    #1;
    do_reset(1'b0);
    for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, '0);
    step(1'b0, 8'd0, 1'b1, 1'b1, 128'd0);
    chk("zero_seed_lfsr", dut.lfsr, 128'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'd0, 1'b1, 1'b0, '0);
    chk("warm_done_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, '0);
    step(1'b1, 8'h5a, 1'b1, 1'b0, '0);
    step(1'b1, 8'ha5, 1'b1, 1'b0, '0);
    rnd_steps(200);
    step(1'b1, 8'h3c, 1'b0, 1'b0, '0);
    step(1'b0, 8'd0, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, '0);
    for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, '0);
    rnd_steps(150);
    step(1'b1, 8'h77, 1'b0, 1'b0, '0);
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, '0);
    step(1'b0, 8'd0, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 16; i++) step(1'b0, 8'd0, 1'b0, 1'b0, '0);
    rnd_steps(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
